// File: rtl/uart_rx_pkg.sv
// rtl/uart_rx_pkg.sv - shared UART receiver states and framing constants
package uart_rx_pkg;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4
    } state_t;

    // Oversampling ticks per bit period
    localparam int OVS = 16;
    // Tick index at the middle of the start bit
    localparam int MID = 7;

endpackage

// File: rtl/uart_rx_if.sv
// rtl/uart_rx_if.sv - serial input and received-byte bundle for uart_rx
interface uart_rx_if #(
    parameter int DBIT = 8
) ();
    logic            rx;
    logic            s_tick;
    logic [DBIT-1:0] dout;
    logic            rx_done;
    logic            parity_err;
    logic            frame_err;

    // Line/tick source and result consumer
    modport master (
        output rx, s_tick,
        input  dout, rx_done, parity_err, frame_err
    );

    // Receiver side
    modport slave (
        input  rx, s_tick,
        output dout, rx_done, parity_err, frame_err
    );
endinterface

// File: rtl/uart_rx_sync_2ff.sv
// rtl/uart_rx_sync_2ff.sv - two-flop synchronizer, resets to line-idle high
module uart_rx_sync_2ff (
    input  logic clk,
    input  logic reset,
    input  logic d,
    output logic q
);
    logic meta;

    // Two register stages; reset to 1 so a reset never looks like a start edge
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            meta <= 1'b1;
            q    <= 1'b1;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end
endmodule

// File: rtl/uart_rx.sv
// rtl/uart_rx.sv - 16x oversampling UART receiver with parity and stop checks
module uart_rx
    import uart_rx_pkg::*;
#(
    parameter int DBIT       = 8,
    parameter int SB_TICK    = 16,
    parameter int PARITY_EN  = 0,
    parameter int PARITY_ODD = 0
) (
    input  logic     clk,
    input  logic     reset,
    uart_rx_if.slave bus
);
    localparam int SW = (SB_TICK > 16) ? 5 : 4;
    localparam int NW = (DBIT > 1) ? $clog2(DBIT) : 1;

    localparam logic [SW-1:0] S_MID  = SW'(MID);
    localparam logic [SW-1:0] S_BIT  = SW'(OVS - 1);
    localparam logic [SW-1:0] S_STOP = SW'(SB_TICK - 1);
    localparam logic [NW-1:0] N_LAST = NW'(DBIT - 1);
    localparam logic          P_EN   = (PARITY_EN != 0);
    localparam logic          P_ODD  = (PARITY_ODD != 0);

    state_t          state;
    logic [SW-1:0]   s;
    logic [NW-1:0]   n;
    logic [DBIT-1:0] shift;
    logic            p;
    logic            rx_s;
    logic            rx_prev;
    logic [DBIT-1:0] dout_r;
    logic            done_r;
    logic            perr_r;
    logic            ferr_r;

    uart_rx_sync_2ff u_sync (
        .clk   (clk),
        .reset (reset),
        .d     (bus.rx),
        .q     (rx_s)
    );

    // Frame FSM: counters move only on s_tick, outputs registered on stop sample
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state   <= IDLE;
            s       <= '0;
            n       <= '0;
            shift   <= '0;
            p       <= 1'b0;
            rx_prev <= 1'b1;
            dout_r  <= '0;
            done_r  <= 1'b0;
            perr_r  <= 1'b0;
            ferr_r  <= 1'b0;
        end else begin
            rx_prev <= rx_s;
            done_r  <= 1'b0;
            case (state)
                IDLE: begin
                    // Edge, not level: a held-low line must return high to re-arm
                    if (!rx_s && rx_prev) begin
                        state <= START;
                        s     <= '0;
                    end
                end
                START: begin
                    if (bus.s_tick) begin
                        if (s == S_MID) begin
                            s <= '0;
                            if (!rx_s) begin
                                state <= DATA;
                                n     <= '0;
                            end else begin
                                state <= IDLE;
                            end
                        end else begin
                            s <= s + 1'b1;
                        end
                    end
                end
                DATA: begin
                    if (bus.s_tick) begin
                        if (s == S_BIT) begin
                            s     <= '0;
                            shift <= {rx_s, shift[DBIT-1:1]};
                            if (n == N_LAST) begin
                                state <= P_EN ? PARITY : STOP;
                            end else begin
                                n <= n + 1'b1;
                            end
                        end else begin
                            s <= s + 1'b1;
                        end
                    end
                end
                PARITY: begin
                    if (bus.s_tick) begin
                        if (s == S_BIT) begin
                            s     <= '0;
                            p     <= rx_s;
                            state <= STOP;
                        end else begin
                            s <= s + 1'b1;
                        end
                    end
                end
                STOP: begin
                    if (bus.s_tick) begin
                        if (s == S_STOP) begin
                            s      <= '0;
                            state  <= IDLE;
                            dout_r <= shift;
                            ferr_r <= ~rx_s;
                            perr_r <= P_EN & ((^shift) ^ p ^ P_ODD);
                            done_r <= 1'b1;
                        end else begin
                            s <= s + 1'b1;
                        end
                    end
                end
                default: begin
                    state <= IDLE;
                    s     <= '0;
                end
            endcase
        end
    end

    assign bus.dout       = dout_r;
    assign bus.rx_done    = done_r;
    assign bus.parity_err = perr_r;
    assign bus.frame_err  = ferr_r;
endmodule

// File: tb/tb_uart_rx.sv
// tb/tb_uart_rx.sv - scoreboard bench for uart_rx, plain and even-parity instances
module tb_uart_rx;

    typedef struct {
        logic [7:0] d;
        logic       pe;
        logic       fe;
    } exp_t;

    logic clk;
    logic reset;

    uart_rx_if #(.DBIT(8)) bus0 ();
    uart_rx_if #(.DBIT(8)) bus1 ();

    uart_rx #(.DBIT(8), .SB_TICK(16), .PARITY_EN(0), .PARITY_ODD(0)) u0 (
        .clk   (clk),
        .reset (reset),
        .bus   (bus0)
    );

    uart_rx #(.DBIT(8), .SB_TICK(16), .PARITY_EN(1), .PARITY_ODD(0)) u1 (
        .clk   (clk),
        .reset (reset),
        .bus   (bus1)
    );

    exp_t q0[$];
    exp_t q1[$];
    int   errs   = 0;
    int   checks = 0;
    int   done0  = 0;
    int   done1  = 0;
    logic prev0  = 1'b0;
    logic prev1  = 1'b0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errs++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // s_tick once every 4 clocks, shared by both receivers
    initial begin
        int cnt;
        cnt = 0;
        bus0.s_tick = 1'b0;
        bus1.s_tick = 1'b0;
        forever begin
            @(negedge clk);
            cnt = (cnt + 1) % 4;
            bus0.s_tick = (cnt == 0);
            bus1.s_tick = (cnt == 0);
        end
    end

    // Pop and compare on every rx_done; also flag strobes wider than one cycle
    always @(negedge clk) begin
        if (bus0.rx_done) begin
            exp_t e;
            done0++;
            if (prev0) check("done0_width", 32'd2, 32'd1);
            if (q0.size() == 0) begin
                check("unexpected_done0", 32'd1, 32'd0);
            end else begin
                e = q0.pop_front();
                check("dout0", 32'(bus0.dout), 32'(e.d));
                check("perr0", 32'(bus0.parity_err), 32'(e.pe));
                check("ferr0", 32'(bus0.frame_err), 32'(e.fe));
            end
        end
        if (bus1.rx_done) begin
            exp_t e;
            done1++;
            if (prev1) check("done1_width", 32'd2, 32'd1);
            if (q1.size() == 0) begin
                check("unexpected_done1", 32'd1, 32'd0);
            end else begin
                e = q1.pop_front();
                check("dout1", 32'(bus1.dout), 32'(e.d));
                check("perr1", 32'(bus1.parity_err), 32'(e.pe));
                check("ferr1", 32'(bus1.frame_err), 32'(e.fe));
            end
        end
        prev0 = bus0.rx_done;
        prev1 = bus1.rx_done;
    end

    task automatic set_line(input int which, input logic v);
        if (which == 0) bus0.rx = v;
        else            bus1.rx = v;
    endtask

    // One bit period = 16 ticks = 64 clocks
    task automatic bit_time(input int nbits);
        repeat (64 * nbits) @(negedge clk);
    endtask

    // Leaves the line at the stop value so frames can run back to back
    task automatic send_frame(input int which, input logic [7:0] d, input bit par_en,
                              input logic par, input logic stop);
        set_line(which, 1'b0);
        bit_time(1);
        for (int i = 0; i < 8; i++) begin
            set_line(which, d[i]);
            bit_time(1);
        end
        if (par_en) begin
            set_line(which, par);
            bit_time(1);
        end
        set_line(which, stop);
        bit_time(1);
    endtask

    task automatic push0(input logic [7:0] d, input logic fe);
        exp_t e;
        e.d = d; e.pe = 1'b0; e.fe = fe;
        q0.push_back(e);
    endtask

    // Even parity: data ones plus the parity bit must be even
    task automatic push1(input logic [7:0] d, input logic par);
        exp_t e;
        e.d = d; e.pe = (^d) ^ par; e.fe = 1'b0;
        q1.push_back(e);
    endtask

    task automatic drain(input string tag, input int budget);
        int k;
        k = 0;
        while ((q0.size() != 0 || q1.size() != 0) && k < budget) begin
            @(negedge clk);
            k++;
        end
        if (q0.size() != 0 || q1.size() != 0)
            check(tag, 32'(q0.size() + q1.size()), 32'd0);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_dout"}, 32'(bus0.dout), 32'd0);
        check({tag, "_done"}, 32'(bus0.rx_done), 32'd0);
        check({tag, "_perr"}, 32'(bus0.parity_err), 32'd0);
        check({tag, "_ferr"}, 32'(bus0.frame_err), 32'd0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] b2b [3];
        b2b[0] = 8'h00; b2b[1] = 8'hFF; b2b[2] = 8'h3C;

        reset = 1'b0;
        bus0.rx = 1'b1;
        bus1.rx = 1'b1;
        repeat (4) @(negedge clk);
        check_reset_outputs("reset");
        check("reset_done1", 32'(bus1.rx_done), 32'd0);
        reset = 1'b1;
        bit_time(1);

        // Single frame
        push0(8'hA5, 1'b0);
        send_frame(0, 8'hA5, 1'b0, 1'b0, 1'b1);
        drain("drain_a5", 200);
        bit_time(1);

        // Back to back, no idle gap between stop and next start
        for (int i = 0; i < 3; i++) begin
            push0(b2b[i], 1'b0);
            send_frame(0, b2b[i], 1'b0, 1'b0, 1'b1);
        end
        drain("drain_b2b", 200);
        bit_time(1);

        // 5-tick glitch is rejected at the start-bit midpoint
        set_line(0, 1'b0);
        repeat (20) @(negedge clk);
        set_line(0, 1'b1);
        bit_time(2);
        push0(8'h81, 1'b0);
        send_frame(0, 8'h81, 1'b0, 1'b0, 1'b1);
        drain("drain_81", 200);
        bit_time(1);

        // Stop bit low, then line held low: one errored frame, no re-arm
        push0(8'h55, 1'b1);
        send_frame(0, 8'h55, 1'b0, 1'b0, 1'b0);
        drain("drain_55", 200);
        bit_time(3);
        set_line(0, 1'b1);
        bit_time(1);
        push0(8'h66, 1'b0);
        send_frame(0, 8'h66, 1'b0, 1'b0, 1'b1);
        drain("drain_66", 200);
        bit_time(1);

        // Parity instance: correct parity then wrong parity
        push1(8'h07, 1'b1);
        send_frame(1, 8'h07, 1'b1, 1'b1, 1'b1);
        push1(8'h07, 1'b0);
        send_frame(1, 8'h07, 1'b1, 1'b0, 1'b1);
        drain("drain_par", 200);
        bit_time(1);

        // Reset in the middle of data bit 3 of 0xF0 aborts the frame
        set_line(0, 1'b0);
        bit_time(1);
        for (int i = 0; i < 3; i++) begin
            set_line(0, 1'b0);
            bit_time(1);
        end
        repeat (32) @(negedge clk);
        reset = 1'b0;
        set_line(0, 1'b1);
        repeat (3) @(negedge clk);
        check_reset_outputs("midreset");
        reset = 1'b1;
        bit_time(3);
        push0(8'h12, 1'b0);
        send_frame(0, 8'h12, 1'b0, 1'b0, 1'b1);
        drain("drain_12", 200);
        bit_time(2);

        check("done0_count", 32'(done0), 32'd8);
        check("done1_count", 32'(done1), 32'd2);
        check("q0_left", 32'(q0.size()), 32'd0);
        check("q1_left", 32'(q1.size()), 32'd0);

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end

endmodule
